// File: rtl/cam_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : cam_cfg_seq
// Brief    : Camera register-init sequencer. Walks a small register table and
//            feeds {DEV_ADDR, reg, data} writes to the downstream i2c master,
//            one at a time, with soft-reset delay entries (reg 8'hFF).
//            Optional NACK retry is enabled by defining CFG_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cam_cfg_seq #(
    parameter logic [7:0] DEV_ADDR       = 8'h42,
    parameter int         NUM_REGS       = 4,
    parameter int         GAP_CYCLES     = 250,
    parameter int         TIMEOUT_CYCLES = 4095,
    parameter int         MAX_RETRY      = 3
) (
    input  logic        meg25,
    input  logic        rst,
    input  logic        start,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic [23:0] send_dat,
    output logic        sendit,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  reg_idx
);

    localparam logic [7:0]  c_LAST_IDX = 8'(NUM_REGS - 1);
    localparam logic [19:0] c_GAP_LOAD = 20'(GAP_CYCLES - 1);
    localparam logic [19:0] c_TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DELAY = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [19:0] r_cnt,   w_cnt_nxt;
    logic [7:0]  r_idx,   w_idx_nxt;
    logic [23:0] r_dat,   w_dat_nxt;
    logic [15:0] w_rom;
    logic        w_is_delay;

`ifdef CFG_RETRY_EN
    localparam int c_RW = $clog2(MAX_RETRY + 1);
    logic [c_RW-1:0] r_retry, w_retry_nxt;
    // Set while a NACKed entry is sitting out its gap, so the gap ends by
    // reloading the same entry instead of advancing.
    logic            r_redo,  w_redo_nxt;
`endif

    // Register table: {reg_addr, data}; reg 8'hFF is a delay of data*1024 cycles.
    always_comb begin
        case (r_idx)
            8'd0:    w_rom = 16'h1280;
            8'd1:    w_rom = 16'hFF0A;
            8'd2:    w_rom = 16'h1101;
            8'd3:    w_rom = 16'h40D0;
            default: w_rom = 16'hFFFF;
        endcase
    end

    assign w_is_delay = (w_rom[15:8] == 8'hFF);

    // Next-state and datapath update; one shared counter serves WAIT (up) and GAP/DELAY (down).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dat_nxt   = r_dat;
`ifdef CFG_RETRY_EN
        w_retry_nxt = r_retry;
        w_redo_nxt  = r_redo;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = 8'd0;
                    w_cnt_nxt   = 20'd0;
`ifdef CFG_RETRY_EN
                    w_retry_nxt = '0;
                    w_redo_nxt  = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (w_is_delay) begin
                    w_state_nxt = S_DELAY;
                    w_cnt_nxt   = {2'b00, w_rom[7:0], 10'b0};
                end else begin
                    w_state_nxt = S_SEND;
                    w_dat_nxt   = {DEV_ADDR, w_rom};
                end
            end
            S_SEND: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = 20'd0;
            end
            S_WAIT: begin
                // A completion on the final timeout cycle still counts as success.
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = c_GAP_LOAD;
                    end else begin
`ifdef CFG_RETRY_EN
                        if (r_retry < c_RW'(MAX_RETRY)) begin
                            w_retry_nxt = r_retry + 1'b1;
                            w_redo_nxt  = 1'b1;
                            w_state_nxt = S_GAP;
                            w_cnt_nxt   = c_GAP_LOAD;
                        end else begin
                            w_state_nxt = S_ERR;
                        end
`else
                        w_state_nxt = S_ERR;
`endif
                    end
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
            S_GAP, S_DELAY: begin
                if (r_cnt != 20'd0) begin
                    w_cnt_nxt = r_cnt - 20'd1;
                end else begin
`ifdef CFG_RETRY_EN
                    if (r_redo) begin
                        w_redo_nxt  = 1'b0;
                        w_state_nxt = S_LOAD;
                    end else
`endif
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_state_nxt = S_LOAD;
`ifdef CFG_RETRY_EN
                        w_retry_nxt = '0;
`endif
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge meg25) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 20'd0;
            r_idx   <= 8'd0;
            r_dat   <= 24'd0;
`ifdef CFG_RETRY_EN
            r_retry <= '0;
            r_redo  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dat   <= w_dat_nxt;
`ifdef CFG_RETRY_EN
            r_retry <= w_retry_nxt;
            r_redo  <= w_redo_nxt;
`endif
        end
    end

    // Status flags are decoded straight from the registered state.
    assign send_dat = r_dat;
    assign reg_idx  = r_idx;
    assign sendit   = (r_state == S_SEND);
    assign cfg_done = (r_state == S_DONE);
    assign cfg_err  = (r_state == S_ERR);
    assign cfg_busy = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);

endmodule
`default_nettype wire
